apa102_frame_streamer: RTL and testbench

- Upstream feeder for the byte-wide SPI master (reg_width=8) in the POV clock LED path.
- Holds an RGB pixel buffer written by the display logic and streams one APA102 frame on request: start frame, per-LED words, end frame.
- Issues one SPI byte at a time through the master's t_start / d_in / transmit_done handshake.

---
 rtl/apa102_frame_streamer.sv | 150 +++++++++++++++
 tb/tb_apa102_frame_streamer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_frame_streamer.sv
// Streams one APA102 frame (start, per-LED words, end) from a pixel buffer through a byte-wide SPI master.
// Optional: define APA102_DOUBLE_BUFFER_EN for two pixel banks that swap when a frame is accepted.
module apa102_frame_streamer #(
  parameter int num_leds   = 32,
  parameter int addr_width = (num_leds > 1) ? $clog2(num_leds) : 1,
  parameter int end_bytes  = (num_leds + 15) / 16
) (
  input  logic                  module_clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [23:0]           wr_data,
  input  logic [4:0]            brightness,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  spi_t_start,
  output logic [7:0]            spi_d_in,
  output logic [3:0]            spi_t_size,
  input  logic                  spi_transmit_done
);

  localparam int cnt_width = $clog2(4 * num_leds);
  localparam logic [cnt_width-1:0] start_last = cnt_width'(3);
  localparam logic [cnt_width-1:0] led_last   = cnt_width'(4 * num_leds - 1);
  localparam logic [cnt_width-1:0] end_last   = cnt_width'(end_bytes - 1);

  typedef enum logic [2:0] {IDLE, START, LED, END_FRAME, DONE} phase_t;
  typedef enum logic {ISSUE, WAIT} sub_t;

  phase_t                phase, phase_nxt;
  sub_t                  sub, sub_nxt;
  logic [cnt_width-1:0]  byte_cnt, byte_nxt;
  logic [addr_width-1:0] led_idx, led_nxt, rd_addr;
  logic [4:0]            bright_lat;
  logic [23:0]           shadow;
  logic                  accept, rd_en, wr_ok;

  assign spi_t_size = 4'd8;
  assign busy       = (phase != IDLE) && (phase != DONE);
  assign wr_ok      = wr_en && (int'(wr_addr) < num_leds);
  // Next pixel to fetch: LED 0 at the end of the start frame, otherwise the one after the current LED.
  assign rd_addr    = (phase == START) ? '0 : led_idx + addr_width'(1);

`ifdef APA102_DOUBLE_BUFFER_EN
  logic [23:0] pixel_ram [2][num_leds];
  logic        front_bank;

  always_ff @(posedge module_clk or negedge rst_n) begin
    if (!rst_n)      front_bank <= 1'b0;
    else if (accept) front_bank <= ~front_bank;
  end

  always_ff @(posedge module_clk) begin
    if (wr_ok) pixel_ram[~front_bank][wr_addr] <= wr_data;
    if (rd_en) shadow <= pixel_ram[front_bank][rd_addr];
  end
`else
  logic [23:0] pixel_ram [num_leds];

  always_ff @(posedge module_clk) begin
    if (wr_ok) pixel_ram[wr_addr] <= wr_data;
    if (rd_en) shadow <= pixel_ram[rd_addr];
  end
`endif

  always_ff @(posedge module_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= IDLE;
      sub        <= ISSUE;
      byte_cnt   <= '0;
      led_idx    <= '0;
      bright_lat <= '0;
    end else begin
      phase    <= phase_nxt;
      sub      <= sub_nxt;
      byte_cnt <= byte_nxt;
      led_idx  <= led_nxt;
      if (accept) bright_lat <= brightness;
    end
  end

  // Counters only advance on transmit_done, so spi_d_in stays put for the whole WAIT window.
  always_comb begin
    phase_nxt   = phase;
    sub_nxt     = sub;
    byte_nxt    = byte_cnt;
    led_nxt     = led_idx;
    accept      = 1'b0;
    rd_en       = 1'b0;
    frame_done  = 1'b0;
    spi_t_start = 1'b0;
    spi_d_in    = 8'h00;

    case (phase)
      LED: begin
        case (byte_cnt[1:0])
          2'd0:    spi_d_in = {3'b111, bright_lat};
          2'd1:    spi_d_in = shadow[7:0];
          2'd2:    spi_d_in = shadow[15:8];
          default: spi_d_in = shadow[23:16];
        endcase
      end
      END_FRAME: spi_d_in = 8'hFF;
      default:   spi_d_in = 8'h00;
    endcase

    case (phase)
      IDLE: begin
        if (frame_start) begin
          accept    = 1'b1;
          phase_nxt = START;
          sub_nxt   = ISSUE;
          byte_nxt  = '0;
          led_nxt   = '0;
        end
      end
      START, LED, END_FRAME: begin
        if (sub == ISSUE) begin
          spi_t_start = 1'b1;
          sub_nxt     = WAIT;
        end else if (spi_transmit_done) begin
          sub_nxt  = ISSUE;
          byte_nxt = byte_cnt + cnt_width'(1);
          if (phase == START && byte_cnt == start_last) begin
            phase_nxt = LED;
            byte_nxt  = '0;
            rd_en     = 1'b1;
          end else if (phase == LED && byte_cnt == led_last) begin
            phase_nxt = END_FRAME;
            byte_nxt  = '0;
            led_nxt   = '0;
          end else if (phase == LED && byte_cnt[1:0] == 2'd3) begin
            led_nxt = led_idx + addr_width'(1);
            rd_en   = 1'b1;
          end else if (phase == END_FRAME && byte_cnt == end_last) begin
            phase_nxt = DONE;
            byte_nxt  = '0;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        phase_nxt  = IDLE;
      end
      default: phase_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apa102_frame_streamer.sv
// Self-checking bench: an SPI master model pops expected bytes from a scoreboard filled when each frame is requested.
module tb_apa102_frame_streamer;

  localparam int num_leds    = 32;
  localparam int frame_bytes = 4 + 4 * num_leds + 2;

  logic        module_clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [23:0] wr_data;
  logic [4:0]  brightness;
  logic        frame_start;
  logic        busy;
  logic        frame_done;
  logic        spi_t_start;
  logic [7:0]  spi_d_in;
  logic [3:0]  spi_t_size;
  logic        spi_transmit_done;

  logic [7:0]  sb_q[$];
  logic [23:0] model_px [2][num_leds];
  logic        wr_bank = 1'b0;
  int          check_count = 0;
  int          pass_count = 0;
  int          tstart_count = 0;
  int          done_count = 0;
  int          spi_delay = 1;
  int          spi_cnt = 0;
  logic        spi_busy = 1'b0;
  logic [7:0]  held_byte = 8'h00;

  apa102_frame_streamer dut (
    .module_clk        (module_clk),
    .rst_n             (rst_n),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .brightness        (brightness),
    .frame_start       (frame_start),
    .busy              (busy),
    .frame_done        (frame_done),
    .spi_t_start       (spi_t_start),
    .spi_d_in          (spi_d_in),
    .spi_t_size        (spi_t_size),
    .spi_transmit_done (spi_transmit_done)
  );

  always #5 module_clk = ~module_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  // SPI master model: accepts a byte on t_start and signals completion spi_delay cycles later.
  initial begin
    spi_transmit_done = 1'b0;
    forever begin
      @(negedge module_clk);
      if (!rst_n) begin
        spi_busy = 1'b0;
        spi_transmit_done = 1'b0;
      end else begin
        spi_transmit_done = 1'b0;
        if (frame_done) done_count++;
        if (spi_busy) begin
          checkOutput("tstart_in_wait", 32'(spi_t_start), 32'd0);
          checkOutput("din_stable", 32'(spi_d_in), 32'(held_byte));
          spi_cnt--;
          if (spi_cnt == 0) begin
            spi_transmit_done = 1'b1;
            spi_busy = 1'b0;
          end
        end else if (spi_t_start) begin
          tstart_count++;
          if (sb_q.size() == 0) checkOutput("unexpected_byte", 32'(sb_q.size()), 32'd1);
          else checkOutput("byte", 32'(spi_d_in), 32'(sb_q.pop_front()));
          held_byte = spi_d_in;
          spi_busy = 1'b1;
          spi_cnt = spi_delay;
        end
      end
    end
  end

  task automatic write_pixel(input int addr, input logic [23:0] data);
    @(negedge module_clk);
    wr_en = 1'b1;
    wr_addr = addr[4:0];
    wr_data = data;
    @(negedge module_clk);
    wr_en = 1'b0;
    model_px[wr_bank][addr] = data;
  endtask

  task automatic fill_all(input bit zero);
    logic [31:0] r;
    for (int i = 0; i < num_leds; i++) begin
      r = $urandom();
      if (zero) write_pixel(i, 24'h0);
      else if (i == 0) write_pixel(i, 24'h112233);
      else if (i == 1) write_pixel(i, 24'h445566);
      else write_pixel(i, r[23:0]);
    end
  endtask

  // Requests one frame and follows it to completion; abort_at > 0 resets the DUT once that many bytes were issued.
  task automatic applyStimulus(input logic [4:0] bright, input int delay, input bit repulse,
                               input bit coincide, input int abort_at);
    int   base_tstart, base_done;
    bit   got_done;
    logic rd_bank;
    base_tstart = tstart_count;
    base_done = done_count;
    got_done = 1'b0;
    spi_delay = delay;
    rd_bank = wr_bank;
`ifdef APA102_DOUBLE_BUFFER_EN
    wr_bank = ~wr_bank;
`endif
    for (int i = 0; i < 4; i++) sb_q.push_back(8'h00);
    for (int i = 0; i < num_leds; i++) begin
      sb_q.push_back({3'b111, bright});
      sb_q.push_back(model_px[rd_bank][i][7:0]);
      sb_q.push_back(model_px[rd_bank][i][15:8]);
      sb_q.push_back(model_px[rd_bank][i][23:16]);
    end
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'hFF);

    @(negedge module_clk);
    brightness = bright;
    frame_start = 1'b1;
    @(negedge module_clk);
    #1;
    frame_start = 1'b0;
    brightness = bright ^ 5'h0A;
    checkOutput("busy_rise", 32'(busy), 32'd1);

    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge module_clk);
      #1;
      if (repulse) frame_start = (cyc == 10);
      if (abort_at > 0 && (tstart_count - base_tstart) == abort_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_tstart", 32'(spi_t_start), 32'd0);
        checkOutput("abort_din", 32'(spi_d_in), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge module_clk);
        rst_n = 1'b1;
        return;
      end
      if (frame_done) begin
        got_done = 1'b1;
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        if (coincide) frame_start = 1'b1;
        @(negedge module_clk);
        frame_start = 1'b0;
        break;
      end
      checkOutput("busy_high", 32'(busy), 32'd1);
    end
    checkOutput("frame_completed", 32'(got_done), 32'd1);
    repeat (20) @(negedge module_clk);
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("byte_count", 32'(tstart_count - base_tstart), 32'(frame_bytes));
    checkOutput("done_count", 32'(done_count - base_done), 32'd1);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    brightness = '0;
    frame_start = 1'b0;
    repeat (3) @(negedge module_clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_tstart", 32'(spi_t_start), 32'd0);
    checkOutput("rst_din", 32'(spi_d_in), 32'd0);
    checkOutput("t_size", 32'(spi_t_size), 32'd8);
    rst_n = 1'b1;

    $display("[TB] basic frame, pixels 0/1 = 112233/445566");
    fill_all(1'b0);
    applyStimulus(5'h1F, 1, 1'b0, 1'b0, 0);

    $display("[TB] re-pulse mid-frame and at frame_done");
    fill_all(1'b0);
    applyStimulus(5'h03, 3, 1'b1, 1'b1, 0);
    applyStimulus(5'h11, 2, 1'b0, 1'b0, 0);

    $display("[TB] all-zero pixels");
    fill_all(1'b1);
    applyStimulus(5'h05, 2, 1'b0, 1'b0, 0);

    $display("[TB] slow SPI, 40 cycles per byte");
    applyStimulus(5'h0A, 40, 1'b0, 1'b0, 0);

    $display("[TB] reset during LED byte 50");
    applyStimulus(5'h1F, 2, 1'b0, 1'b0, 55);
    fill_all(1'b0);
    applyStimulus(5'h1F, 1, 1'b0, 1'b0, 0);

`ifdef APA102_DOUBLE_BUFFER_EN
    $display("[TB] double buffer: write pixel 31 during frame 1");
    fill_all(1'b0);
    applyStimulus(5'h1F, 1, 1'b0, 1'b0, 0);
    fill_all(1'b0);
    fork
      applyStimulus(5'h1F, 2, 1'b0, 1'b0, 0);
      begin
        repeat (30) @(negedge module_clk);
        write_pixel(31, 24'hABCDEF);
      end
    join
    applyStimulus(5'h1F, 1, 1'b0, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
